// File: rtl/test_seq_if.sv
// Vector-memory load, run control, DUT stimulus/response and result lines for test_seq.
interface test_seq_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic [AW:0]   len;
    logic          p1;
    logic          p2;
    logic          p3;
    logic          p4;
    logic          p5;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic          fail_valid;
    logic [AW-1:0] first_fail;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, p3, p4, p5,
        input  p1, p2, busy, done, pass, err_cnt, fail_valid, first_fail
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, p3, p4, p5,
        output p1, p2, busy, done, pass, err_cnt, fail_valid, first_fail
    );
endinterface

// File: rtl/test_seq.sv
// Plays stored vectors into a DUT and checks its responses LAT cycles later.
// Optional macro TEST_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module test_seq #(
    parameter int DEPTH = 16,
    parameter int LAT   = 1
) (
    input logic       CK,
    input logic       RS,
    test_seq_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   n_q;
    logic [AW:0]   cnt_q;
    logic [2:0]    dcnt_q;
    logic          p1_q;
    logic          p2_q;
    logic [AW:0]   err_cnt_q;
    logic          fail_valid_q;
    logic [AW-1:0] first_fail_q;

    logic [2:0]    exp_p  [LAT+1];
    logic [2:0]    mask_p [LAT+1];
    logic [AW-1:0] idx_p  [LAT+1];
    logic          vld_p  [LAT+1];

    logic          busy;
    logic          idle_like;
    logic          issue;
    logic          mis;
    logic          stop_hit;
    logic [AW:0]   len_clip;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_word;

    function automatic logic vec_mismatch(input logic [2:0] resp, input logic [2:0] expv,
                                          input logic [2:0] mask);
        return |((resp ^ expv) & mask);
    endfunction

    assign busy      = (state == RUN) || (state == DRAIN);
    assign idle_like = (state == IDLE) || (state == DONE);
    assign len_clip  = (bus.len > DEPTH_W) ? DEPTH_W : bus.len;
    assign mis       = vld_p[LAT] && vec_mismatch({bus.p5, bus.p4, bus.p3}, exp_p[LAT], mask_p[LAT]);

`ifdef TEST_SEQ_STOP_ON_FAIL_EN
    assign stop_hit = mis;
`else
    assign stop_hit = 1'b0;
`endif

    // A vector is issued on the start edge (entry 0) and on each RUN edge until n are out.
    always_comb begin
        issue   = 1'b0;
        rd_addr = cnt_q[AW-1:0];
        if (idle_like && bus.start && (len_clip != '0)) begin
            issue   = 1'b1;
            rd_addr = '0;
        end else if ((state == RUN) && (cnt_q < n_q)) begin
            issue = 1'b1;
        end
        if (stop_hit) issue = 1'b0;
    end

    assign rd_word = mem[rd_addr];

    always_ff @(posedge CK) begin
        if (bus.wr_en && !busy) mem[bus.wr_addr] <= bus.wr_data;
    end

    // p0: vector being driven; pN: vector driven N cycles ago, compared at pLAT
    always_ff @(posedge CK) begin
        exp_p[0]  <= rd_word[4:2];
        mask_p[0] <= rd_word[7:5];
        idx_p[0]  <= rd_addr;
        for (int j = 1; j <= LAT; j++) begin
            exp_p[j]  <= exp_p[j-1];
            mask_p[j] <= mask_p[j-1];
            idx_p[j]  <= idx_p[j-1];
        end
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            state        <= IDLE;
            p1_q         <= 1'b0;
            p2_q         <= 1'b0;
            n_q          <= '0;
            cnt_q        <= '0;
            dcnt_q       <= '0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            for (int j = 0; j <= LAT; j++) vld_p[j] <= 1'b0;
        end else begin
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            vld_p[0] <= issue;
            for (int j = 1; j <= LAT; j++) vld_p[j] <= vld_p[j-1];
            if (issue) begin
                p1_q <= rd_word[0];
                p2_q <= rd_word[1];
            end
            if (mis) begin
                err_cnt_q <= err_cnt_q + 1'b1;
                if (!fail_valid_q) begin
                    fail_valid_q <= 1'b1;
                    first_fail_q <= idx_p[LAT];
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        n_q          <= len_clip;
                        cnt_q        <= (AW+1)'(1);
                        err_cnt_q    <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        state        <= (len_clip == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (cnt_q < n_q) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (LAT == 0) begin
                        state <= DONE;
                    end else begin
                        state  <= DRAIN;
                        dcnt_q <= 3'(LAT);
                    end
                end
                DRAIN: begin
                    if (dcnt_q == 3'd1) state <= DONE;
                    else                dcnt_q <= dcnt_q - 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (stop_hit) begin
                state <= DONE;
                for (int j = 0; j <= LAT; j++) vld_p[j] <= 1'b0;
            end
        end
    end

    assign bus.p1         = p1_q;
    assign bus.p2         = p2_q;
    assign bus.busy       = busy;
    assign bus.done       = (state == DONE);
    assign bus.pass       = (state == DONE) && !fail_valid_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;
endmodule
